// File: rtl/power_ctrl_if.sv
// power_ctrl_if: button/activity inputs and power-state outputs of the power controller.
// The controller connects through the slave modport; the driving side uses master.
interface power_ctrl_if;
    logic power_btn;
    logic activity;
    logic power;
    logic power_on_pulse;
    logic power_off_pulse;

    modport master (
        output power_btn,
        output activity,
        input  power,
        input  power_on_pulse,
        input  power_off_pulse
    );

    modport slave (
        input  power_btn,
        input  activity,
        output power,
        output power_on_pulse,
        output power_off_pulse
    );
endinterface

// File: rtl/power_ctrl.sv
// power_ctrl: synchronised, debounced push-button power sequencer (short press on, long press off).
// Define AUTO_OFF_EN to add the inactivity auto-off timer; otherwise the activity input is ignored.
//
// state      | meaning
// S_OFF      | powered off, waiting for a debounced press
// S_ON_HOLD  | powered on, waiting for the power-on press to be released
// S_ON       | powered on, timing presses for a long-press power-off
// S_OFF_HOLD | powered off by long press, waiting for release
module power_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 2_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int IDLE_CYCLES       = 1_000_000_000
) (
    input  logic        clk,
    input  logic        rst,
    power_ctrl_if.slave bus
);
    localparam int DEB_W  = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_ON_HOLD  = 2'd1,
        S_ON       = 2'd2,
        S_OFF_HOLD = 2'd3
    } state_t;

    logic              r_sync_1;
    logic              r_sync_2;
    logic              r_btn_db;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_power;
    logic              w_power_nxt;
    logic              r_on_pulse;
    logic              w_on_pulse_nxt;
    logic              r_off_pulse;
    logic              w_off_pulse_nxt;

`ifdef AUTO_OFF_EN
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic [IDLE_W-1:0] w_idle_nxt;
`else
    logic w_unused_activity;
    assign w_unused_activity = bus.activity;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_1 <= 1'b0;
            r_sync_2 <= 1'b0;
        end else begin
            r_sync_1 <= bus.power_btn;
            r_sync_2 <= r_sync_1;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_db  <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync_2 == r_btn_db) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_btn_db  <= r_sync_2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_OFF;
            r_power     <= 1'b0;
            r_on_pulse  <= 1'b0;
            r_off_pulse <= 1'b0;
            r_hold_cnt  <= '0;
`ifdef AUTO_OFF_EN
            r_idle_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_power     <= w_power_nxt;
            r_on_pulse  <= w_on_pulse_nxt;
            r_off_pulse <= w_off_pulse_nxt;
            r_hold_cnt  <= w_hold_nxt;
`ifdef AUTO_OFF_EN
            r_idle_cnt  <= w_idle_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_power_nxt     = r_power;
        w_on_pulse_nxt  = 1'b0;
        w_off_pulse_nxt = 1'b0;
        w_hold_nxt      = '0;
`ifdef AUTO_OFF_EN
        w_idle_nxt      = '0;
`endif
        case (r_state)
            S_OFF: begin
                if (r_btn_db) begin
                    w_state_nxt    = S_ON_HOLD;
                    w_power_nxt    = 1'b1;
                    w_on_pulse_nxt = 1'b1;
                end
            end
            S_ON_HOLD: begin
                if (!r_btn_db) begin
                    w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                // Long press only counts while pressed; idle expiry needs the button released,
                // so the two power-off causes can never fire on the same cycle.
                if (r_btn_db) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt     = S_OFF_HOLD;
                        w_power_nxt     = 1'b0;
                        w_off_pulse_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
`ifdef AUTO_OFF_EN
                else if (!bus.activity) begin
                    if (r_idle_cnt == IDLE_LAST) begin
                        w_state_nxt     = S_OFF;
                        w_power_nxt     = 1'b0;
                        w_off_pulse_nxt = 1'b1;
                    end else begin
                        w_idle_nxt = r_idle_cnt + 1'b1;
                    end
                end
`endif
            end
            S_OFF_HOLD: begin
                if (!r_btn_db) begin
                    w_state_nxt = S_OFF;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
                w_power_nxt = 1'b0;
            end
        endcase
    end

    assign bus.power           = r_power;
    assign bus.power_on_pulse  = r_on_pulse;
    assign bus.power_off_pulse = r_off_pulse;
endmodule

// File: tb/tb_power_ctrl.sv
// tb_power_ctrl: table-driven scenarios, exact-latency sequences and randomized button/activity
// traffic, all compared cycle by cycle against an abstract behavioural model.
module tb_power_ctrl;
    localparam int DEB  = 4;
    localparam int LP   = 20;
    localparam int IDLE = 50;
`ifdef AUTO_OFF_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    power_ctrl_if ifc();

    power_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LP),
        .IDLE_CYCLES      (IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: raw sample history, synchronised-sample history, and abstract power status.
    bit raw_q[$];
    bit s_hist[$];
    bit m_db;
    bit m_power;
    bit m_wait_release;
    int m_hold_run;
    int m_idle_run;

    typedef struct {
        bit btn;
        bit act;
        int ncyc;
        bit exp_power;
        int exp_on;
        int exp_off;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        s_hist.delete();
        m_db           = 1'b0;
        m_power        = 1'b0;
        m_wait_release = 1'b0;
        m_hold_run     = 0;
        m_idle_run     = 0;
    endtask

    // One clock: advance the model on the inputs seen at the edge, then compare all outputs.
    task automatic tick();
        bit s_now;
        bit db_now;
        bit all_differ;
        bit on_p;
        bit off_p;
        @(posedge clk);
        s_now = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
        raw_q.push_back(ifc.power_btn);
        if (raw_q.size() > 4) void'(raw_q.pop_front());
        db_now = m_db;

        s_hist.push_back(s_now);
        if (s_hist.size() > DEB) void'(s_hist.pop_front());
        if (s_hist.size() == DEB) begin
            all_differ = 1'b1;
            foreach (s_hist[i]) if (s_hist[i] == m_db) all_differ = 1'b0;
            if (all_differ) begin
                m_db = s_now;
                s_hist.delete();
            end
        end

        on_p  = 1'b0;
        off_p = 1'b0;
        if (m_wait_release) begin
            if (!db_now) m_wait_release = 1'b0;
        end else if (!m_power) begin
            if (db_now) begin
                m_power        = 1'b1;
                on_p           = 1'b1;
                m_wait_release = 1'b1;
            end
        end else begin
            m_hold_run = db_now ? m_hold_run + 1 : 0;
            m_idle_run = (db_now || ifc.activity) ? 0 : m_idle_run + 1;
            if (m_hold_run == LP) begin
                m_power        = 1'b0;
                off_p          = 1'b1;
                m_wait_release = 1'b1;
            end else if (AUTO && m_idle_run == IDLE) begin
                m_power = 1'b0;
                off_p   = 1'b1;
            end
            if (!m_power) begin
                m_hold_run = 0;
                m_idle_run = 0;
            end
        end
        #1;
        chk("model", {ifc.power, ifc.power_on_pulse, ifc.power_off_pulse}, {m_power, on_p, off_p});
    endtask

    initial begin
        int n_on;
        int n_off;

        ifc.power_btn = 1'b0;
        ifc.activity  = 1'b0;
        rst           = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_power", ifc.power, 0);
        chk("reset_on_pulse", ifc.power_on_pulse, 0);
        chk("reset_off_pulse", ifc.power_off_pulse, 0);
        rst = 1'b0;

        //             btn  act ncyc pwr  on off
        vecs.push_back('{1, 0, 2,   0,   0, 0});
        vecs.push_back('{0, 0, 2,   0,   0, 0});
        vecs.push_back('{1, 0, 2,   0,   0, 0});
        vecs.push_back('{0, 0, 2,   0,   0, 0});
        vecs.push_back('{0, 0, 10,  0,   0, 0});
        vecs.push_back('{1, 0, 6,   0,   0, 0});
        vecs.push_back('{1, 0, 1,   1,   1, 0});
        vecs.push_back('{1, 0, 30,  1,   0, 0});
        vecs.push_back('{0, 0, 10,  1,   0, 0});
        vecs.push_back('{1, 1, 15,  1,   0, 0});
        vecs.push_back('{0, 1, 20,  1,   0, 0});
        vecs.push_back('{1, 1, 15,  1,   0, 0});
        vecs.push_back('{0, 1, 20,  1,   0, 0});
        vecs.push_back('{1, 1, 26,  0,   0, 1});
        vecs.push_back('{1, 1, 100, 0,   0, 0});
        vecs.push_back('{0, 1, 10,  0,   0, 0});
        vecs.push_back('{1, 1, 7,   1,   1, 0});
        vecs.push_back('{0, 1, 10,  1,   0, 0});
        vecs.push_back('{0, 0, 60,  !AUTO, 0, int'(AUTO)});
        vecs.push_back('{1, 1, 7,   1,   int'(AUTO), 0});
        vecs.push_back('{0, 1, 10,  1,   0, 0});

        foreach (vecs[r]) begin
            ifc.power_btn = vecs[r].btn;
            ifc.activity  = vecs[r].act;
            n_on  = 0;
            n_off = 0;
            for (int c = 0; c < vecs[r].ncyc; c++) begin
                tick();
                n_on  += int'(ifc.power_on_pulse);
                n_off += int'(ifc.power_off_pulse);
            end
            chk($sformatf("row%0d_power", r), ifc.power, vecs[r].exp_power);
            chk($sformatf("row%0d_on_pulses", r), n_on, vecs[r].exp_on);
            chk($sformatf("row%0d_off_pulses", r), n_off, vecs[r].exp_off);
        end

        // Long press from ON: exact 26-edge latency and a single off pulse.
        ifc.power_btn = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            tick();
            chk($sformatf("lp_power_e%0d", e), ifc.power, (e < 26) ? 1 : 0);
            chk($sformatf("lp_off_e%0d", e), ifc.power_off_pulse, (e == 26) ? 1 : 0);
        end
        n_on = 0;
        repeat (100) begin
            tick();
            n_on += int'(ifc.power_on_pulse);
        end
        chk("hold_after_off_power", ifc.power, 0);
        chk("hold_after_off_on_pulses", n_on, 0);
        ifc.power_btn = 1'b0;
        repeat (10) tick();

        // Clean press from OFF: power rises after exactly 7 edges.
        ifc.power_btn = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("on_power_e%0d", e), ifc.power, (e >= 7) ? 1 : 0);
            chk($sformatf("on_pulse_e%0d", e), ifc.power_on_pulse, (e == 7) ? 1 : 0);
        end
        ifc.power_btn = 1'b0;
        repeat (10) tick();

        // Idle timer restarted by a single activity cycle at the last idle cycle.
        n_off = 0;
        ifc.activity = 1'b0;
        repeat (49) begin tick(); n_off += int'(ifc.power_off_pulse); end
        ifc.activity = 1'b1;
        tick();
        n_off += int'(ifc.power_off_pulse);
        ifc.activity = 1'b0;
        repeat (49) begin tick(); n_off += int'(ifc.power_off_pulse); end
        chk("idle_restart_power", ifc.power, 1);
        chk("idle_restart_off_pulses", n_off, 0);
        tick();
        chk("idle_expire_power", ifc.power, AUTO ? 0 : 1);
        chk("idle_expire_off_pulse", ifc.power_off_pulse, AUTO ? 1 : 0);
        ifc.activity  = 1'b1;
        ifc.power_btn = 1'b1;
        repeat (7) tick();
        ifc.power_btn = 1'b0;
        repeat (10) tick();
        chk("before_rst_power", ifc.power, 1);

        // Reset during a long press, button still held across deassert.
        ifc.power_btn = 1'b1;
        repeat (16) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_power", ifc.power, 0);
        chk("rst_async_on_pulse", ifc.power_on_pulse, 0);
        chk("rst_async_off_pulse", ifc.power_off_pulse, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("post_rst_power_e%0d", e), ifc.power, (e >= 7) ? 1 : 0);
        end

        // Randomized bounce, short presses, long holds and activity.
        for (int cyc = 0; cyc < 3000; ) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            if (kind == 0)      len = $urandom_range(1, 3);
            else if (kind == 1) len = $urandom_range(4, 10);
            else                len = $urandom_range(15, 60);
            ifc.power_btn = 1'($urandom_range(0, 1));
            ifc.activity  = ($urandom_range(0, 4) == 0);
            repeat (len) tick();
            cyc += len;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
